// File: rtl/melody_sequencer.sv
// Melody sequencer: steps a melody ROM at a fixed tempo and drives the speaker block with a
// tone divider and a symmetric amplitude pair, with play/pause/restart and saturating volume.
module melody_sequencer #(
  parameter int          CLK_FREQ    = 100_000_000,
  parameter int          BEAT_CYCLES = 12_500_000,
  parameter int          GAP_CYCLES  = 1_000_000,
  parameter int          LEN         = 64,
  parameter int          ADDR_W      = 6,
  parameter int          MAX_VOL     = 5,
  parameter int          VOL_RESET   = 3,
  parameter logic [15:0] AMP_STEP    = 16'h1000,
  parameter int          LOOP        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              restart,
  input  logic              vol_up,
  input  logic              vol_down,
  input  logic [4:0]        note_code,
  output logic [ADDR_W-1:0] beat_addr,
  output logic [21:0]       note_div,
  output logic [15:0]       audio_min,
  output logic [15:0]       audio_max,
  output logic [2:0]        vol_level,
  output logic              playing,
  output logic              done
);

  localparam int CNT_W     = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int SOUND_END = BEAT_CYCLES - GAP_CYCLES;

  if (GAP_CYCLES >= BEAT_CYCLES) begin : g_gap_chk
    $error("GAP_CYCLES must be smaller than BEAT_CYCLES");
  end
  if (LEN > (1 << ADDR_W)) begin : g_len_chk
    $error("LEN does not fit in ADDR_W address bits");
  end
  if (MAX_VOL * int'(AMP_STEP) >= (1 << 15)) begin : g_amp_chk
    $error("MAX_VOL * AMP_STEP must fit in 15 bits");
  end
  if (MAX_VOL > 7 || VOL_RESET > MAX_VOL) begin : g_vol_chk
    $error("volume levels must fit in 3 bits and VOL_RESET must not exceed MAX_VOL");
  end

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_DONE} state_t;

  // Octave-4 base frequencies in Hz, index 0 = C .. 11 = B.
  function automatic int base_freq(input int idx);
    case (idx)
      0:  return 262;
      1:  return 277;
      2:  return 294;
      3:  return 311;
      4:  return 330;
      5:  return 349;
      6:  return 370;
      7:  return 392;
      8:  return 415;
      9:  return 440;
      10: return 466;
      default: return 494;
    endcase
  endfunction

  // Entries 0..11 are octave 4, entries 12..23 the doubled-frequency octave.
  function automatic logic [24*22-1:0] build_div_tab();
    logic [24*22-1:0] tab;
    int               f;
    tab = '0;
    for (int i = 0; i < 24; i++) begin
      f = base_freq(i % 12) * ((i >= 12) ? 2 : 1);
      tab[i*22 +: 22] = 22'(CLK_FREQ / f);
    end
    return tab;
  endfunction

  localparam logic [24*22-1:0] DIV_TAB = build_div_tab();

  function automatic logic note_is_valid(input logic [4:0] code);
    return (code[3:0] >= 4'd1) && (code[3:0] <= 4'd12);
  endfunction

  function automatic logic [21:0] note_divisor(input logic [4:0] code);
    int idx;
    idx = (code[4] ? 12 : 0) + int'(code[3:0]) - 1;
    if (idx < 0 || idx > 23) idx = 0;
    return DIV_TAB[idx*22 +: 22];
  endfunction

  function automatic logic [2:0] vol_step(input logic [2:0] v, input logic up, input logic dn);
    if (up && !dn && (v < 3'(MAX_VOL))) return v + 3'd1;
    if (dn && !up && (v != 3'd0))       return v - 3'd1;
    return v;
  endfunction

  function automatic logic signed [15:0] vol_amp(input logic [2:0] v);
    return 16'(int'(v) * int'(AMP_STEP));
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0]    beat_addr_q, beat_addr_d;
  logic [2:0]           vol_q, vol_d;
  logic [21:0]          note_div_q, note_div_d;
  logic signed [15:0]   audio_max_q, audio_max_d;
  logic signed [15:0]   audio_min_q, audio_min_d;
  logic                 playing_q, playing_d;
  logic                 done_q, done_d;
  logic                 beat_last;
  logic                 sounding;

  assign beat_last = (beat_cnt_q == CNT_W'(BEAT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    beat_addr_d = beat_addr_q;
    vol_d       = vol_step(vol_q, vol_up, vol_down);

    // The beat only advances on cycles where playback stays in PLAY, so a pause freezes it exactly.
    unique case (state_q)
      S_IDLE:  if (play) state_d = S_PLAY;
      S_PLAY: begin
        if (!play) begin
          state_d = S_PAUSE;
        end else if (beat_last) begin
          beat_cnt_d = '0;
          if (beat_addr_q == ADDR_W'(LEN - 1)) begin
            if (LOOP != 0) beat_addr_d = '0;
            else           state_d     = S_DONE;
          end else begin
            beat_addr_d = beat_addr_q + 1'b1;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      S_PAUSE: if (play) state_d = S_PLAY;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (restart) begin
      state_d     = S_IDLE;
      beat_cnt_d  = '0;
      beat_addr_d = '0;
    end

    playing_d = (state_d == S_PLAY);
    done_d    = (state_d == S_DONE);
  end

  // Speaker outputs are registered from the current state, beat position, note and volume.
  always_comb begin
    sounding = (state_q == S_PLAY) && note_is_valid(note_code) &&
               (beat_cnt_q < CNT_W'(SOUND_END)) && (vol_q != 3'd0);

    note_div_d = note_div_q;
    if ((state_q == S_PLAY) && note_is_valid(note_code)) note_div_d = note_divisor(note_code);

    audio_max_d = '0;
    audio_min_d = '0;
    if (sounding) begin
      audio_max_d = vol_amp(vol_q);
      audio_min_d = -vol_amp(vol_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      beat_cnt_q  <= '0;
      beat_addr_q <= '0;
      vol_q       <= 3'(VOL_RESET);
      note_div_q  <= '0;
      audio_max_q <= '0;
      audio_min_q <= '0;
      playing_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      beat_addr_q <= beat_addr_d;
      vol_q       <= vol_d;
      note_div_q  <= note_div_d;
      audio_max_q <= audio_max_d;
      audio_min_q <= audio_min_d;
      playing_q   <= playing_d;
      done_q      <= done_d;
    end
  end

  assign beat_addr = beat_addr_q;
  assign note_div  = note_div_q;
  assign audio_max = audio_max_q;
  assign audio_min = audio_min_q;
  assign vol_level = vol_q;
  assign playing   = playing_q;
  assign done      = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: a looping and a one-shot instance share stimulus; a 4-beat ROM
// exercises notes, octave, rest, gap, pause, volume, restart and reset.
module tb_melody_sequencer;

  logic        clk = 1'b0;
  logic        rst, play, restart, vol_up, vol_down;
  logic [4:0]  code_a, code_b;
  logic [1:0]  addr_a, addr_b;
  logic [21:0] div_a, div_b;
  logic [15:0] min_a, max_a, min_b, max_b;
  logic [2:0]  vol_a, vol_b;
  logic        playing_a, playing_b, done_a, done_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  always #5 clk = ~clk;

  function automatic logic [4:0] rom(input logic [1:0] a);
    case (a)
      2'd0: return 5'h0A;
      2'd1: return 5'h1A;
      2'd2: return 5'h00;
      default: return 5'h01;
    endcase
  endfunction

  assign code_a = rom(addr_a);
  assign code_b = rom(addr_b);

  melody_sequencer #(.CLK_FREQ(100_000_000), .BEAT_CYCLES(100), .GAP_CYCLES(10), .LEN(4),
                     .ADDR_W(2), .MAX_VOL(5), .VOL_RESET(3), .AMP_STEP(16'h1000), .LOOP(1))
  dut_loop (.clk(clk), .rst(rst), .play(play), .restart(restart), .vol_up(vol_up),
            .vol_down(vol_down), .note_code(code_a), .beat_addr(addr_a), .note_div(div_a),
            .audio_min(min_a), .audio_max(max_a), .vol_level(vol_a), .playing(playing_a),
            .done(done_a));

  melody_sequencer #(.CLK_FREQ(100_000_000), .BEAT_CYCLES(100), .GAP_CYCLES(10), .LEN(4),
                     .ADDR_W(2), .MAX_VOL(5), .VOL_RESET(3), .AMP_STEP(16'h1000), .LOOP(0))
  dut_once (.clk(clk), .rst(rst), .play(play), .restart(restart), .vol_up(vol_up),
            .vol_down(vol_down), .note_code(code_b), .beat_addr(addr_b), .note_div(div_b),
            .audio_min(min_b), .audio_max(max_b), .vol_level(vol_b), .playing(playing_b),
            .done(done_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; play = 1'b0; restart = 1'b0; vol_up = 1'b0; vol_down = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++; if (div_a !== 22'd0) begin errors++; $display("FAIL reset_div: got %0d want 0", div_a); end
    checks++; if (max_a !== 16'h0 || min_a !== 16'h0) begin errors++; $display("FAIL reset_amp: got %h/%h want 0/0", max_a, min_a); end
    checks++; if (vol_a !== 3'd3) begin errors++; $display("FAIL reset_vol: got %0d want 3", vol_a); end
    checks++; if (addr_a !== 2'd0 || playing_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL reset_ctrl: addr %0d playing %b done %b want 0 0 0", addr_a, playing_a, done_a); end
  endtask

  // Edge counting below: E1 is the edge that takes IDLE to PLAY; beat n spans E(100n+1)..E(100n+100).
  task automatic test_first_note();
    play = 1'b1;
    exp_q.push_back(32'd227272);
    exp_q.push_back(32'h3000);
    exp_q.push_back(32'hD000);
    tick();
    checks++; if (playing_a !== 1'b1) begin errors++; $display("FAIL play_start: playing %b want 1", playing_a); end
    checks++; if (div_a !== 22'd0) begin errors++; $display("FAIL div_latency: got %0d want 0", div_a); end
    tick();
    exp = exp_q.pop_front();
    checks++; if (div_a !== exp[21:0]) begin errors++; $display("FAIL a4_div: got %0d want %0d", div_a, exp); end
    exp = exp_q.pop_front();
    checks++; if (max_a !== exp[15:0]) begin errors++; $display("FAIL a4_max: got %h want %h", max_a, exp[15:0]); end
    exp = exp_q.pop_front();
    checks++; if (min_a !== exp[15:0]) begin errors++; $display("FAIL a4_min: got %h want %h", min_a, exp[15:0]); end
  endtask

  task automatic test_gap();
    repeat (89) tick();
    checks++; if (max_a !== 16'h3000) begin errors++; $display("FAIL pre_gap_amp: got %h want 3000", max_a); end
    tick();
    checks++; if (max_a !== 16'h0 || min_a !== 16'h0) begin errors++; $display("FAIL gap_amp: got %h/%h want 0/0", max_a, min_a); end
    checks++; if (div_a !== 22'd227272) begin errors++; $display("FAIL gap_div: got %0d want 227272", div_a); end
    repeat (8) tick();
    checks++; if (addr_a !== 2'd0) begin errors++; $display("FAIL beat0_len: addr %0d want 0", addr_a); end
    tick();
    checks++; if (addr_a !== 2'd1) begin errors++; $display("FAIL beat1_addr: addr %0d want 1", addr_a); end
    exp_q.push_back(32'd113636);
    tick();
    exp = exp_q.pop_front();
    checks++; if (div_a !== exp[21:0]) begin errors++; $display("FAIL a5_div: got %0d want %0d", div_a, exp); end
    checks++; if (max_a !== 16'h3000) begin errors++; $display("FAIL a5_amp: got %h want 3000", max_a); end
  endtask

  task automatic test_rest_and_end();
    repeat (99) tick();
    checks++; if (addr_a !== 2'd2) begin errors++; $display("FAIL beat2_addr: addr %0d want 2", addr_a); end
    tick();
    checks++; if (max_a !== 16'h0) begin errors++; $display("FAIL rest_amp: got %h want 0", max_a); end
    checks++; if (div_a !== 22'd113636) begin errors++; $display("FAIL rest_div_hold: got %0d want 113636", div_a); end
    repeat (99) tick();
    exp_q.push_back(32'd381679);
    tick();
    exp = exp_q.pop_front();
    checks++; if (div_a !== exp[21:0] || max_a !== 16'h3000) begin errors++; $display("FAIL c4_note: div %0d amp %h want %0d 3000", div_a, max_a, exp); end
    repeat (99) tick();
    checks++; if (addr_a !== 2'd0 || playing_a !== 1'b1) begin errors++; $display("FAIL loop_wrap: addr %0d playing %b want 0 1", addr_a, playing_a); end
    checks++; if (done_b !== 1'b1 || playing_b !== 1'b0 || addr_b !== 2'd3) begin errors++; $display("FAIL once_done: done %b playing %b addr %0d want 1 0 3", done_b, playing_b, addr_b); end
    tick();
    checks++; if (max_b !== 16'h0 || min_b !== 16'h0) begin errors++; $display("FAIL done_amp: got %h/%h want 0/0", max_b, min_b); end
    checks++; if (div_a !== 22'd227272 || max_a !== 16'h3000) begin errors++; $display("FAIL loop_note: div %0d amp %h want 227272 3000", div_a, max_a); end
  endtask

  task automatic test_pause();
    repeat (39) tick();
    play = 1'b0;
    tick();
    checks++; if (playing_a !== 1'b0) begin errors++; $display("FAIL pause_state: playing %b want 0", playing_a); end
    repeat (49) tick();
    checks++; if (max_a !== 16'h0 || addr_a !== 2'd0) begin errors++; $display("FAIL pause_frozen: amp %h addr %0d want 0 0", max_a, addr_a); end
    play = 1'b1;
    repeat (2) tick();
    checks++; if (playing_a !== 1'b1 || max_a !== 16'h3000) begin errors++; $display("FAIL resume: playing %b amp %h want 1 3000", playing_a, max_a); end
    repeat (58) tick();
    checks++; if (addr_a !== 2'd0) begin errors++; $display("FAIL resume_len: addr %0d want 0", addr_a); end
    tick();
    checks++; if (addr_a !== 2'd1) begin errors++; $display("FAIL resume_adv: addr %0d want 1", addr_a); end
  endtask

  task automatic test_volume();
    vol_up = 1'b1;
    repeat (5) tick();
    vol_up = 1'b0;
    checks++; if (vol_a !== 3'd5) begin errors++; $display("FAIL vol_sat_hi: got %0d want 5", vol_a); end
    checks++; if (max_a !== 16'h5000 || min_a !== 16'hB000) begin errors++; $display("FAIL vol5_amp: got %h/%h want 5000/b000", max_a, min_a); end
    vol_up = 1'b1; vol_down = 1'b1;
    tick();
    vol_up = 1'b0; vol_down = 1'b0;
    checks++; if (vol_a !== 3'd5) begin errors++; $display("FAIL vol_both: got %0d want 5", vol_a); end
    vol_down = 1'b1;
    repeat (5) tick();
    vol_down = 1'b0;
    checks++; if (vol_a !== 3'd0) begin errors++; $display("FAIL vol_sat_lo: got %0d want 0", vol_a); end
    tick();
    checks++; if (max_a !== 16'h0 || min_a !== 16'h0 || playing_a !== 1'b1) begin errors++; $display("FAIL vol0_mute: amp %h/%h playing %b want 0/0 1", max_a, min_a, playing_a); end
    vol_up = 1'b1;
    repeat (3) tick();
    vol_up = 1'b0;
    tick();
    checks++; if (vol_a !== 3'd3 || max_a !== 16'h3000) begin errors++; $display("FAIL vol_restore: vol %0d amp %h want 3 3000", vol_a, max_a); end
  endtask

  task automatic test_restart();
    int n;
    n = 0;
    while (addr_a !== 2'd2 && n < 300) begin
      tick();
      n++;
    end
    checks++; if (addr_a !== 2'd2) begin errors++; $display("FAIL wait_beat2: addr %0d want 2 within 300 cycles", addr_a); end
    restart = 1'b1; vol_up = 1'b1;
    tick();
    restart = 1'b0; vol_up = 1'b0;
    checks++; if (addr_a !== 2'd0 || playing_a !== 1'b0 || vol_a !== 3'd4) begin errors++; $display("FAIL restart: addr %0d playing %b vol %0d want 0 0 4", addr_a, playing_a, vol_a); end
    checks++; if (done_b !== 1'b0) begin errors++; $display("FAIL restart_done: done %b want 0", done_b); end
    tick();
    checks++; if (playing_a !== 1'b1 || playing_b !== 1'b1) begin errors++; $display("FAIL restart_play: playing %b/%b want 1/1", playing_a, playing_b); end
    tick();
    checks++; if (div_a !== 22'd227272 || max_a !== 16'h4000) begin errors++; $display("FAIL restart_note: div %0d amp %h want 227272 4000", div_a, max_a); end
  endtask

  task automatic test_reset_mid();
    repeat (30) tick();
    rst = 1'b1;
    tick();
    checks++; if (div_a !== 22'd0 || max_a !== 16'h0 || min_a !== 16'h0) begin errors++; $display("FAIL rst_mid_out: div %0d amp %h/%h want 0 0/0", div_a, max_a, min_a); end
    checks++; if (vol_a !== 3'd3 || addr_a !== 2'd0 || playing_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: vol %0d addr %0d playing %b done %b want 3 0 0 0", vol_a, addr_a, playing_a, done_a); end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_first_note();
    test_gap();
    test_rest_and_end();
    test_pause();
    test_volume();
    test_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
